io_port_bridge: RTL and testbench

//  Byte-stream bridge on the RISCY 8-bit bidirectional IO port; replaces the bench's

---
 rtl/riscy_io_pkg.sv | 7 +
 rtl/io_port_bridge_byte_fifo.sv | 44 ++++
 rtl/io_port_bridge.sv | 87 ++++++++
 tb/tb_io_port_bridge.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscy_io_pkg.sv
// rtl/riscy_io_pkg.sv - shared constants and types for the RISCY IO port bridge
package riscy_io_pkg;
  localparam int IO_W = 8;
  typedef logic [IO_W-1:0] byte_t;
  localparam int ERR_TX_OVF = 0;
  localparam int ERR_RX_UDF = 1;
endpackage

// File: rtl/io_port_bridge_byte_fifo.sv
// rtl/io_port_bridge_byte_fifo.sv - byte FIFO with wrap-bit pointers
// The caller qualifies push/pop against full/empty; this block trusts them.
module byte_fifo
  import riscy_io_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  byte_t       i_data,
  input  logic        i_pop,
  output byte_t       o_data,
  output logic        o_full,
  output logic        o_empty,
  output logic [AW:0] o_count
);

  logic [AW:0] r_wr;
  logic [AW:0] r_rd;
  byte_t       r_mem [DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (i_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed when non-empty.
  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  assign o_data  = r_mem[r_rd[AW-1:0]];
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_count = r_wr - r_rd;

endmodule

// File: rtl/io_port_bridge.sv
// rtl/io_port_bridge.sv - RISCY IO port to TX/RX byte stream bridge
// Optional sticky ERR port when IO_BRIDGE_ERR_EN is defined.
module io_port_bridge
  import riscy_io_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST_,
  input  logic          PDR,
  input  logic          PORT_EN,
  input  logic          PORT_RD,
  inout  wire [IO_W-1:0] IO,
  output byte_t         TX_DATA,
  output logic          TX_VALID,
  input  logic          TX_READY,
  input  byte_t         RX_DATA,
  input  logic          RX_VALID,
  output logic          RX_READY,
  output logic [AW:0]   TX_COUNT,
  output logic [AW:0]   RX_COUNT
`ifdef IO_BRIDGE_ERR_EN
  ,
  output logic [1:0]    ERR
`endif
);

  logic  w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic  w_tx_wr, w_tx_push, w_tx_pop, w_rx_rd, w_rx_push, w_rx_pop;
  byte_t w_rx_head;

  assign w_tx_wr   = PORT_EN && PDR;
  assign w_tx_pop  = TX_VALID && TX_READY;
  // A full TX FIFO still accepts a write when the head leaves in the same cycle.
  assign w_tx_push = w_tx_wr && (!w_tx_full || w_tx_pop);
  assign w_rx_rd   = PORT_RD && !PDR;
  assign w_rx_pop  = w_rx_rd && !w_rx_empty;
  assign w_rx_push = RX_VALID && RX_READY;

  assign TX_VALID  = !w_tx_empty;
  assign RX_READY  = !w_rx_full;

  byte_fifo #(.DEPTH(DEPTH)) tx_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_),
    .i_push  (w_tx_push),
    .i_data  (IO),
    .i_pop   (w_tx_pop),
    .o_data  (TX_DATA),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty),
    .o_count (TX_COUNT)
  );

  byte_fifo #(.DEPTH(DEPTH)) rx_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST_),
    .i_push  (w_rx_push),
    .i_data  (RX_DATA),
    .i_pop   (w_rx_pop),
    .o_data  (w_rx_head),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty),
    .o_count (RX_COUNT)
  );

  assign IO = (RST_ && !PDR) ? (w_rx_empty ? '0 : w_rx_head) : {IO_W{1'bz}};

`ifdef IO_BRIDGE_ERR_EN
  logic [1:0] r_err;

  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      r_err <= '0;
    end else if (PORT_EN && !PDR) begin
      r_err <= '0;
    end else begin
      if (w_tx_wr && w_tx_full && !w_tx_pop) r_err[ERR_TX_OVF] <= 1'b1;
      if (w_rx_rd && w_rx_empty)             r_err[ERR_RX_UDF] <= 1'b1;
    end
  end

  assign ERR = r_err;
`endif

endmodule

// File: tb/tb_io_port_bridge.sv
// tb/tb_io_port_bridge.sv - self-checking bench for io_port_bridge
module tb_io_port_bridge;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic          RST_, PDR, PORT_EN, PORT_RD, TX_READY, RX_VALID;
  logic          TX_VALID, RX_READY;
  logic [7:0]    TX_DATA, RX_DATA;
  logic [AW:0]   TX_COUNT, RX_COUNT;
  wire  [7:0]    IO;
  logic [7:0]    tb_io_d;
  logic          tb_io_en;
`ifdef IO_BRIDGE_ERR_EN
  logic [1:0]    ERR;
`endif

  assign IO = tb_io_en ? tb_io_d : 8'hzz;

  io_port_bridge #(.DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RST_     (RST_),
    .PDR      (PDR),
    .PORT_EN  (PORT_EN),
    .PORT_RD  (PORT_RD),
    .IO       (IO),
    .TX_DATA  (TX_DATA),
    .TX_VALID (TX_VALID),
    .TX_READY (TX_READY),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .RX_READY (RX_READY),
    .TX_COUNT (TX_COUNT),
    .RX_COUNT (RX_COUNT)
`ifdef IO_BRIDGE_ERR_EN
    ,
    .ERR      (ERR)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       pdr, en, rd, txr, rxv;
    logic [7:0] iod, rxd;
    int         txc, rxc;
    logic [7:0] txd, io;
    logic [1:0] err;
  } vec_t;

  function automatic vec_t mk(logic pdr, logic en, logic rd, logic txr, logic rxv,
                              logic [7:0] iod, logic [7:0] rxd, int txc, int rxc,
                              logic [7:0] txd, logic [7:0] io, logic [1:0] err);
    vec_t v;
    v.pdr = pdr; v.en = en; v.rd = rd; v.txr = txr; v.rxv = rxv;
    v.iod = iod; v.rxd = rxd; v.txc = txc; v.rxc = rxc;
    v.txd = txd; v.io = io; v.err = err;
    return v;
  endfunction

  vec_t tbl[$];

  // Reference model: plain queues driven by the port rules.
  logic [7:0] m_tx[$];
  logic [7:0] m_rx[$];
  logic [1:0] m_err;

  task automatic drive(input logic pdr, input logic en, input logic rd, input logic txr,
                       input logic rxv, input logic [7:0] iod, input logic [7:0] rxd);
    PDR = pdr; PORT_EN = en; PORT_RD = rd; TX_READY = txr;
    RX_VALID = rxv; RX_DATA = rxd; tb_io_d = iod; tb_io_en = pdr;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_txc"}, 32'(TX_COUNT), 32'(m_tx.size()));
    chk({tag, "_rxc"}, 32'(RX_COUNT), 32'(m_rx.size()));
    chk({tag, "_txv"}, 32'(TX_VALID), 32'(m_tx.size() != 0));
    chk({tag, "_rxr"}, 32'(RX_READY), 32'(m_rx.size() < DEPTH));
    if (m_tx.size() != 0) chk({tag, "_txd"}, 32'(TX_DATA), 32'(m_tx[0]));
    if (!PDR) chk({tag, "_io"}, 32'(IO), (m_rx.size() != 0) ? 32'(m_rx[0]) : 32'h0);
`ifdef IO_BRIDGE_ERR_EN
    chk({tag, "_err"}, 32'(ERR), 32'(m_err));
`endif
  endtask

  task automatic model_step();
    bit tx_pop, tx_wr, tx_push, rx_rd, rx_pop, rx_push;
    tx_pop  = (m_tx.size() != 0) && TX_READY;
    tx_wr   = PORT_EN && PDR;
    tx_push = tx_wr && ((m_tx.size() < DEPTH) || tx_pop);
    rx_rd   = PORT_RD && !PDR;
    rx_pop  = rx_rd && (m_rx.size() != 0);
    rx_push = RX_VALID && (m_rx.size() < DEPTH);
    if (PORT_EN && !PDR) m_err = 2'b00;
    else begin
      if (tx_wr && !tx_push) m_err[0] = 1'b1;
      if (rx_rd && m_rx.size() == 0) m_err[1] = 1'b1;
    end
    if (tx_pop)  void'(m_tx.pop_front());
    if (rx_pop)  void'(m_rx.pop_front());
    if (tx_push) m_tx.push_back(IO);
    if (rx_push) m_rx.push_back(RX_DATA);
  endtask

  initial begin
    // TX order, then overflow
    tbl.push_back(mk(1,1,0,0,0,8'h11,8'h00, 1,0,8'h11,8'h00,2'd0));
    tbl.push_back(mk(1,1,0,0,0,8'h22,8'h00, 2,0,8'h11,8'h00,2'd0));
    tbl.push_back(mk(1,1,0,0,0,8'h33,8'h00, 3,0,8'h11,8'h00,2'd0));
    tbl.push_back(mk(1,0,0,1,0,8'h00,8'h00, 2,0,8'h22,8'h00,2'd0));
    tbl.push_back(mk(1,0,0,1,0,8'h00,8'h00, 1,0,8'h33,8'h00,2'd0));
    tbl.push_back(mk(1,0,0,1,0,8'h00,8'h00, 0,0,8'h00,8'h00,2'd0));
    tbl.push_back(mk(1,1,0,0,0,8'hA1,8'h00, 1,0,8'hA1,8'h00,2'd0));
    tbl.push_back(mk(1,1,0,0,0,8'hA2,8'h00, 2,0,8'hA1,8'h00,2'd0));
    tbl.push_back(mk(1,1,0,0,0,8'hA3,8'h00, 3,0,8'hA1,8'h00,2'd0));
    tbl.push_back(mk(1,1,0,0,0,8'hA4,8'h00, 4,0,8'hA1,8'h00,2'd0));
    tbl.push_back(mk(1,1,0,0,0,8'hA5,8'h00, 4,0,8'hA1,8'h00,2'd1));
    tbl.push_back(mk(1,1,0,1,0,8'hA6,8'h00, 4,0,8'hA2,8'h00,2'd1));
    tbl.push_back(mk(1,0,0,1,0,8'h00,8'h00, 3,0,8'hA3,8'h00,2'd1));
    tbl.push_back(mk(1,0,0,1,0,8'h00,8'h00, 2,0,8'hA4,8'h00,2'd1));
    tbl.push_back(mk(1,0,0,1,0,8'h00,8'h00, 1,0,8'hA6,8'h00,2'd1));
    tbl.push_back(mk(1,0,0,1,0,8'h00,8'h00, 0,0,8'h00,8'h00,2'd1));
    // RX path, empty read-through, ignored PORT_EN, full and underflow
    tbl.push_back(mk(0,0,0,0,1,8'h00,8'h80, 0,1,8'h00,8'h80,2'd1));
    tbl.push_back(mk(0,0,0,0,1,8'h00,8'h01, 0,2,8'h00,8'h80,2'd1));
    tbl.push_back(mk(0,0,1,0,0,8'h00,8'h00, 0,1,8'h00,8'h01,2'd1));
    tbl.push_back(mk(0,0,1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,2'd1));
    tbl.push_back(mk(0,0,1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,2'd3));
    tbl.push_back(mk(0,0,1,0,1,8'h00,8'h5C, 0,1,8'h00,8'h5C,2'd3));
    tbl.push_back(mk(0,0,1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,2'd3));
    tbl.push_back(mk(0,1,0,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,2'd0));
    tbl.push_back(mk(0,0,0,0,1,8'h00,8'hC0, 0,1,8'h00,8'hC0,2'd0));
    tbl.push_back(mk(0,0,0,0,1,8'h00,8'hC1, 0,2,8'h00,8'hC0,2'd0));
    tbl.push_back(mk(0,0,0,0,1,8'h00,8'hC2, 0,3,8'h00,8'hC0,2'd0));
    tbl.push_back(mk(0,0,0,0,1,8'h00,8'hC3, 0,4,8'h00,8'hC0,2'd0));
    tbl.push_back(mk(0,0,0,0,1,8'h00,8'hC4, 0,4,8'h00,8'hC0,2'd0));
    tbl.push_back(mk(0,0,1,0,1,8'h00,8'hC5, 0,3,8'h00,8'hC1,2'd0));
    tbl.push_back(mk(0,0,1,0,0,8'h00,8'h00, 0,2,8'h00,8'hC2,2'd0));
    tbl.push_back(mk(0,0,1,0,0,8'h00,8'h00, 0,1,8'h00,8'hC3,2'd0));
    tbl.push_back(mk(0,0,1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,2'd0));
    tbl.push_back(mk(0,0,1,0,0,8'h00,8'h00, 0,0,8'h00,8'h00,2'd2));

    // Reset with RX_VALID high and the bench driving IO: DUT must stay off the pins.
    RST_ = 1'b0;
    drive(0, 0, 0, 0, 1, 8'h5A, 8'h77);
    tb_io_en = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_io_z",  32'(IO), 32'h5A);
    chk("rst_txv",   32'(TX_VALID), 32'h0);
    chk("rst_rxr",   32'(RX_READY), 32'h1);
    chk("rst_txc",   32'(TX_COUNT), 32'h0);
    chk("rst_rxc",   32'(RX_COUNT), 32'h0);
`ifdef IO_BRIDGE_ERR_EN
    chk("rst_err",   32'(ERR), 32'h0);
`endif
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    RST_ = 1'b1;
    @(posedge CLK);
    #1;
    chk("rel_rxc", 32'(RX_COUNT), 32'h0);
    chk("rel_io",  32'(IO), 32'h0);

    foreach (tbl[i]) begin
      drive(tbl[i].pdr, tbl[i].en, tbl[i].rd, tbl[i].txr, tbl[i].rxv, tbl[i].iod, tbl[i].rxd);
      @(posedge CLK);
      #1;
      chk($sformatf("r%0d_txc", i), 32'(TX_COUNT), 32'(tbl[i].txc));
      chk($sformatf("r%0d_rxc", i), 32'(RX_COUNT), 32'(tbl[i].rxc));
      chk($sformatf("r%0d_txv", i), 32'(TX_VALID), 32'(tbl[i].txc != 0));
      chk($sformatf("r%0d_rxr", i), 32'(RX_READY), 32'(tbl[i].rxc != DEPTH));
      if (tbl[i].txc != 0) chk($sformatf("r%0d_txd", i), 32'(TX_DATA), 32'(tbl[i].txd));
      if (!tbl[i].pdr)     chk($sformatf("r%0d_io", i), 32'(IO), 32'(tbl[i].io));
`ifdef IO_BRIDGE_ERR_EN
      chk($sformatf("r%0d_err", i), 32'(ERR), 32'(tbl[i].err));
`endif
    end

    // Mid-operation reset with bytes queued in both directions.
    drive(1, 1, 0, 0, 1, 8'h91, 8'h81);
    @(posedge CLK); #1;
    drive(1, 1, 0, 0, 1, 8'h92, 8'h82);
    @(posedge CLK); #1;
    drive(1, 0, 0, 0, 1, 8'h00, 8'h83);
    @(posedge CLK); #1;
    drive(1, 0, 0, 0, 0, 8'h00, 8'h00);
    chk("mid_txc_pre", 32'(TX_COUNT), 32'h2);
    chk("mid_rxc_pre", 32'(RX_COUNT), 32'h3);
    #2;
    RST_ = 1'b0;
    PDR = 1'b0; tb_io_en = 1'b1; tb_io_d = 8'h3C;
    #1;
    chk("mid_txc", 32'(TX_COUNT), 32'h0);
    chk("mid_rxc", 32'(RX_COUNT), 32'h0);
    chk("mid_txv", 32'(TX_VALID), 32'h0);
    chk("mid_rxr", 32'(RX_READY), 32'h1);
    chk("mid_io_z", 32'(IO), 32'h3C);
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    RST_ = 1'b1;
    @(posedge CLK); #1;
    chk("mid_rel_rxc", 32'(RX_COUNT), 32'h0);
    chk("mid_rel_io",  32'(IO), 32'h0);

    // Randomised traffic against the queue model.
    m_tx.delete(); m_rx.delete(); m_err = 2'b00;
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 3) != 0) ? PDR : ~PDR,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
            8'($urandom), 8'($urandom));
      #1;
      check_model($sformatf("rnd%0d", n));
      model_step();
      @(posedge CLK); #1;
    end
    drive(0, 0, 0, 0, 0, 8'h00, 8'h00);
    #1;
    check_model("rnd_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
